// File: rtl/sdio_host_cmd_phy.sv
// Host-side SDIO CMD-line PHY: sends a 48-bit command frame and, when a reply is
// expected, receives the 48-bit response and checks its CRC7 and end bit.
module sdio_host_cmd_phy #(
  parameter int unsigned RSPS_TIMEOUT = 64,
  parameter int unsigned NRC_CYCLES   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_cmd_stb,
  input  logic [5:0]  i_cmd,
  input  logic [31:0] i_cmd_arg,
  input  logic        i_rsps_en,
  input  logic        i_crc_check,
  output logic        o_idle,
  output logic        o_done_stb,
  output logic [39:0] o_rsps,
  output logic        o_crc_err,
  output logic        o_end_err,
  output logic        o_timeout,
  output logic        o_sdio_cmd_dir,
  output logic        o_sdio_cmd_out,
  input  logic        i_sdio_cmd_in
);

  localparam int unsigned TMR_MAX = (RSPS_TIMEOUT > NRC_CYCLES) ? RSPS_TIMEOUT : NRC_CYCLES;
  localparam int unsigned TW      = $clog2(TMR_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD_TX,
    S_TURN,
    S_WAIT,
    S_RX,
    S_NRC
  } state_t;

  state_t        state_q;
  logic [5:0]    bit_q;
  logic [TW-1:0] tmr_q;
  logic [6:0]    crc_q;
  logic [6:0]    crc_d;
  logic          crc_in;
  logic [6:0]    rx_crc_q;
  logic [39:0]   tx_sr_q;
  logic          rsps_en_q;
  logic          crc_chk_q;
  logic          idle_q;
  logic          done_q;
  logic [39:0]   rsps_q;
  logic          crc_err_q;
  logic          end_err_q;
  logic          timeout_q;
  logic          dir_q;
  logic          out_q;

  function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
    logic fb;
    fb = b ^ c[6];
    return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  // While transmitting, the CRC follows the bit currently on the line.
  always_comb begin
    crc_in = (state_q == S_CMD_TX) ? out_q : i_sdio_cmd_in;
    crc_d  = crc7_step(crc_q, crc_in);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      bit_q     <= '0;
      tmr_q     <= '0;
      crc_q     <= '0;
      rx_crc_q  <= '0;
      tx_sr_q   <= '0;
      rsps_en_q <= 1'b0;
      crc_chk_q <= 1'b0;
      idle_q    <= 1'b1;
      done_q    <= 1'b0;
      rsps_q    <= '0;
      crc_err_q <= 1'b0;
      end_err_q <= 1'b0;
      timeout_q <= 1'b0;
      dir_q     <= 1'b0;
      out_q     <= 1'b1;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          dir_q  <= 1'b0;
          out_q  <= 1'b1;
          idle_q <= 1'b1;
          if (i_cmd_stb) begin
            // Start bit goes out now; the rest of the head waits in the shifter.
            tx_sr_q   <= {1'b1, i_cmd, i_cmd_arg, 1'b0};
            dir_q     <= 1'b1;
            out_q     <= 1'b0;
            bit_q     <= '0;
            crc_q     <= '0;
            rx_crc_q  <= '0;
            rsps_en_q <= i_rsps_en;
            crc_chk_q <= i_crc_check;
            rsps_q    <= '0;
            crc_err_q <= 1'b0;
            end_err_q <= 1'b0;
            timeout_q <= 1'b0;
            idle_q    <= 1'b0;
            state_q   <= S_CMD_TX;
          end
        end

        S_CMD_TX: begin
          bit_q <= bit_q + 6'd1;
          if (bit_q < 6'd40) begin
            crc_q <= crc_d;
          end
          if (bit_q == 6'd39) begin
            out_q   <= crc_d[6];
            tx_sr_q <= {crc_d[5:0], 1'b1, 33'd0};
          end else begin
            out_q   <= tx_sr_q[39];
            tx_sr_q <= {tx_sr_q[38:0], 1'b0};
          end
          if (bit_q == 6'd47) begin
            dir_q <= 1'b0;
            out_q <= 1'b1;
            bit_q <= '0;
            crc_q <= '0;
            tmr_q <= '0;
            if (rsps_en_q) begin
              state_q <= S_TURN;
            end else begin
              done_q  <= 1'b1;
              state_q <= S_NRC;
            end
          end
        end

        S_TURN: begin
          dir_q   <= 1'b0;
          out_q   <= 1'b1;
          tmr_q   <= '0;
          crc_q   <= '0;
          state_q <= S_WAIT;
        end

        S_WAIT: begin
          // A start bit on the expiry clock takes priority over the timeout.
          if (!i_sdio_cmd_in) begin
            rsps_q  <= {rsps_q[38:0], 1'b0};
            crc_q   <= crc_d;
            bit_q   <= 6'd1;
            state_q <= S_RX;
          end else if (tmr_q == TW'(RSPS_TIMEOUT - 1)) begin
            timeout_q <= 1'b1;
            done_q    <= 1'b1;
            tmr_q     <= '0;
            state_q   <= S_NRC;
          end else begin
            tmr_q <= tmr_q + 1'b1;
          end
        end

        S_RX: begin
          if (bit_q < 6'd40) begin
            rsps_q <= {rsps_q[38:0], i_sdio_cmd_in};
            crc_q  <= crc_d;
            bit_q  <= bit_q + 6'd1;
          end else if (bit_q < 6'd47) begin
            rx_crc_q <= {rx_crc_q[5:0], i_sdio_cmd_in};
            bit_q    <= bit_q + 6'd1;
          end else begin
            end_err_q <= !i_sdio_cmd_in;
            crc_err_q <= crc_chk_q && (rx_crc_q != crc_q);
            done_q    <= 1'b1;
            bit_q     <= '0;
            tmr_q     <= '0;
            state_q   <= S_NRC;
          end
        end

        S_NRC: begin
          dir_q <= 1'b0;
          out_q <= 1'b1;
          if (tmr_q == TW'(NRC_CYCLES - 1)) begin
            idle_q  <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            tmr_q <= tmr_q + 1'b1;
          end
        end

        default: begin
          dir_q   <= 1'b0;
          out_q   <= 1'b1;
          idle_q  <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign o_idle         = idle_q;
  assign o_done_stb     = done_q;
  assign o_rsps         = rsps_q;
  assign o_crc_err      = crc_err_q;
  assign o_end_err      = end_err_q;
  assign o_timeout      = timeout_q;
  assign o_sdio_cmd_dir = dir_q;
  assign o_sdio_cmd_out = out_q;

endmodule

// File: tb/tb_sdio_host_cmd_phy.sv
// Directed bench for sdio_host_cmd_phy: frame capture, a scripted device reply,
// error injection, timeout boundary, busy-strobe rejection and mid-frame reset.
module tb_sdio_host_cmd_phy;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_cmd_stb = 1'b0;
  logic [5:0]  i_cmd = '0;
  logic [31:0] i_cmd_arg = '0;
  logic        i_rsps_en = 1'b0;
  logic        i_crc_check = 1'b0;
  logic        o_idle;
  logic        o_done_stb;
  logic [39:0] o_rsps;
  logic        o_crc_err;
  logic        o_end_err;
  logic        o_timeout;
  logic        o_sdio_cmd_dir;
  logic        o_sdio_cmd_out;
  logic        i_sdio_cmd_in = 1'b1;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [47:0] FRAME_CMD0 = 48'h4000_0000_0095;
  localparam logic [47:0] FRAME_CMD8 = 48'h4800_0001_AA87;
  localparam logic [39:0] RSPS_CMD8  = 40'h48_0000_01AA;

  sdio_host_cmd_phy #(.RSPS_TIMEOUT(64), .NRC_CYCLES(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_cmd_stb     (i_cmd_stb),
    .i_cmd         (i_cmd),
    .i_cmd_arg     (i_cmd_arg),
    .i_rsps_en     (i_rsps_en),
    .i_crc_check   (i_crc_check),
    .o_idle        (o_idle),
    .o_done_stb    (o_done_stb),
    .o_rsps        (o_rsps),
    .o_crc_err     (o_crc_err),
    .o_end_err     (o_end_err),
    .o_timeout     (o_timeout),
    .o_sdio_cmd_dir(o_sdio_cmd_dir),
    .o_sdio_cmd_out(o_sdio_cmd_out),
    .i_sdio_cmd_in (i_sdio_cmd_in)
  );

  always #5 clk = ~clk;

  // Issues one command and plays the device side. Observation n is the negedge
  // after accept edge + n. A reply with start_at = j is sampled on the j-th
  // wait-state clock; start_at < 1 keeps the line high.
  task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg,
                         input logic ren, input logic cchk,
                         input logic [47:0] rsp, input int start_at,
                         input int inj_a, input int inj_b,
                         output logic [47:0] frame, output int done_at,
                         output int done_cnt, output int idle_at,
                         output int dir_errs, output logic [39:0] rs,
                         output logic ce, output logic ee, output logic to);
    @(negedge clk);
    i_cmd_stb = 1'b1; i_cmd = idx; i_cmd_arg = arg;
    i_rsps_en = ren;  i_crc_check = cchk;
    @(posedge clk);
    #1;
    i_cmd_stb = 1'b0; i_cmd = 6'h3F; i_cmd_arg = 32'hFFFF_FFFF;
    i_rsps_en = ~ren; i_crc_check = ~cchk;
    frame = '0; done_at = -1; done_cnt = 0; idle_at = -1; dir_errs = 0;
    rs = '0; ce = 1'b0; ee = 1'b0; to = 1'b0;
    for (int n = 0; n < 400 && idle_at < 0; n++) begin
      @(negedge clk);
      if (n < 48) begin
        frame[47-n] = o_sdio_cmd_out;
        if (o_sdio_cmd_dir !== 1'b1) dir_errs++;
      end else if (o_sdio_cmd_dir !== 1'b0 || o_sdio_cmd_out !== 1'b1) begin
        dir_errs++;
      end
      if (o_done_stb === 1'b1) begin
        done_cnt++;
        if (done_at < 0) done_at = n;
        rs = o_rsps; ce = o_crc_err; ee = o_end_err; to = o_timeout;
      end
      if (o_idle === 1'b1) idle_at = n;
      if (start_at >= 1 && n >= 48 + start_at && n < 96 + start_at)
        i_sdio_cmd_in = rsp[47-(n-48-start_at)];
      else
        i_sdio_cmd_in = 1'b1;
      i_cmd_stb = (n == inj_a) || (n == inj_b);
    end
    i_cmd_stb = 1'b0;
    i_sdio_cmd_in = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (o_idle !== 1'b1) begin n_bad++; $display("FAIL reset_idle got=%b exp=1", o_idle); end
    n_cmp++; if (o_done_stb !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b exp=0", o_done_stb); end
    n_cmp++; if (o_rsps !== 40'h0) begin n_bad++; $display("FAIL reset_rsps got=%h exp=0", o_rsps); end
    n_cmp++; if ({o_crc_err, o_end_err, o_timeout} !== 3'b000) begin
      n_bad++; $display("FAIL reset_flags got=%b exp=000", {o_crc_err, o_end_err, o_timeout}); end
    n_cmp++; if ({o_sdio_cmd_dir, o_sdio_cmd_out} !== 2'b01) begin
      n_bad++; $display("FAIL reset_line got=%b exp=01", {o_sdio_cmd_dir, o_sdio_cmd_out}); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_cmd0_no_rsp();
    logic [47:0] fr; int da, dc, ia, de; logic [39:0] rs; logic ce, ee, to;
    run_cmd(6'd0, 32'h0, 1'b0, 1'b1, 48'h0, 0, -1, -1, fr, da, dc, ia, de, rs, ce, ee, to);
    n_cmp++; if (fr !== FRAME_CMD0) begin n_bad++; $display("FAIL cmd0_frame got=%h exp=%h", fr, FRAME_CMD0); end
    n_cmp++; if (da !== 48) begin n_bad++; $display("FAIL cmd0_done_at got=%0d exp=48", da); end
    n_cmp++; if (dc !== 1) begin n_bad++; $display("FAIL cmd0_done_cnt got=%0d exp=1", dc); end
    n_cmp++; if (ia !== 56) begin n_bad++; $display("FAIL cmd0_idle_at got=%0d exp=56", ia); end
    n_cmp++; if (de !== 0) begin n_bad++; $display("FAIL cmd0_line_ctl got=%0d exp=0", de); end
    n_cmp++; if ({ce, ee, to} !== 3'b000) begin n_bad++; $display("FAIL cmd0_flags got=%b exp=000", {ce, ee, to}); end
  endtask

  task automatic test_cmd8_rsp();
    logic [47:0] fr; int da, dc, ia, de; logic [39:0] rs; logic ce, ee, to;
    run_cmd(6'd8, 32'h0000_01AA, 1'b1, 1'b1, FRAME_CMD8, 5, -1, -1, fr, da, dc, ia, de, rs, ce, ee, to);
    n_cmp++; if (fr !== FRAME_CMD8) begin n_bad++; $display("FAIL cmd8_frame got=%h exp=%h", fr, FRAME_CMD8); end
    n_cmp++; if (rs !== RSPS_CMD8) begin n_bad++; $display("FAIL cmd8_rsps got=%h exp=%h", rs, RSPS_CMD8); end
    n_cmp++; if ({ce, ee, to} !== 3'b000) begin n_bad++; $display("FAIL cmd8_flags got=%b exp=000", {ce, ee, to}); end
    n_cmp++; if (da !== 101) begin n_bad++; $display("FAIL cmd8_done_at got=%0d exp=101", da); end
    n_cmp++; if (ia !== 109) begin n_bad++; $display("FAIL cmd8_idle_at got=%0d exp=109", ia); end
    n_cmp++; if (de !== 0) begin n_bad++; $display("FAIL cmd8_line_ctl got=%0d exp=0", de); end
    n_cmp++; if (o_rsps !== RSPS_CMD8) begin n_bad++; $display("FAIL cmd8_rsps_hold got=%h exp=%h", o_rsps, RSPS_CMD8); end
  endtask

  task automatic test_rsp_errors();
    logic [47:0] fr; int da, dc, ia, de; logic [39:0] rs; logic ce, ee, to;
    run_cmd(6'd8, 32'h0000_01AA, 1'b1, 1'b1, FRAME_CMD8 ^ 48'h10_0000, 5, -1, -1, fr, da, dc, ia, de, rs, ce, ee, to);
    n_cmp++; if (ce !== 1'b1) begin n_bad++; $display("FAIL flip_crc_err got=%b exp=1", ce); end
    n_cmp++; if (ee !== 1'b0) begin n_bad++; $display("FAIL flip_end_err got=%b exp=0", ee); end
    n_cmp++; if (rs !== 40'h48_0000_11AA) begin n_bad++; $display("FAIL flip_rsps got=%h exp=48000011aa", rs); end
    run_cmd(6'd8, 32'h0000_01AA, 1'b1, 1'b0, FRAME_CMD8 ^ 48'h10_0000, 5, -1, -1, fr, da, dc, ia, de, rs, ce, ee, to);
    n_cmp++; if (ce !== 1'b0) begin n_bad++; $display("FAIL nocheck_crc_err got=%b exp=0", ce); end
    run_cmd(6'd8, 32'h0000_01AA, 1'b1, 1'b1, 48'h4800_0001_AA86, 5, -1, -1, fr, da, dc, ia, de, rs, ce, ee, to);
    n_cmp++; if (ee !== 1'b1) begin n_bad++; $display("FAIL endbit_end_err got=%b exp=1", ee); end
    n_cmp++; if (ce !== 1'b0) begin n_bad++; $display("FAIL endbit_crc_err got=%b exp=0", ce); end
  endtask

  task automatic test_timeout();
    logic [47:0] fr; int da, dc, ia, de; logic [39:0] rs; logic ce, ee, to;
    run_cmd(6'd8, 32'h0000_01AA, 1'b1, 1'b1, FRAME_CMD8, 0, -1, -1, fr, da, dc, ia, de, rs, ce, ee, to);
    n_cmp++; if (to !== 1'b1) begin n_bad++; $display("FAIL to_flag got=%b exp=1", to); end
    n_cmp++; if (da !== 113) begin n_bad++; $display("FAIL to_done_at got=%0d exp=113", da); end
    n_cmp++; if (rs !== 40'h0) begin n_bad++; $display("FAIL to_rsps got=%h exp=0", rs); end
    n_cmp++; if (ia !== 121) begin n_bad++; $display("FAIL to_idle_at got=%0d exp=121", ia); end
    run_cmd(6'd8, 32'h0000_01AA, 1'b1, 1'b1, FRAME_CMD8, 64, -1, -1, fr, da, dc, ia, de, rs, ce, ee, to);
    n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL edge_to_flag got=%b exp=0", to); end
    n_cmp++; if (da !== 160) begin n_bad++; $display("FAIL edge_done_at got=%0d exp=160", da); end
    n_cmp++; if (rs !== RSPS_CMD8) begin n_bad++; $display("FAIL edge_rsps got=%h exp=%h", rs, RSPS_CMD8); end
    n_cmp++; if ({ce, ee} !== 2'b00) begin n_bad++; $display("FAIL edge_errs got=%b exp=00", {ce, ee}); end
  endtask

  task automatic test_busy_strobe();
    logic [47:0] fr; int da, dc, ia, de; logic [39:0] rs; logic ce, ee, to;
    run_cmd(6'd0, 32'h0, 1'b0, 1'b0, 48'h0, 0, 10, 52, fr, da, dc, ia, de, rs, ce, ee, to);
    n_cmp++; if (fr !== FRAME_CMD0) begin n_bad++; $display("FAIL busy_frame got=%h exp=%h", fr, FRAME_CMD0); end
    n_cmp++; if (dc !== 1) begin n_bad++; $display("FAIL busy_done_cnt got=%0d exp=1", dc); end
    n_cmp++; if (ia !== 56) begin n_bad++; $display("FAIL busy_idle_at got=%0d exp=56", ia); end
    n_cmp++; if (de !== 0) begin n_bad++; $display("FAIL busy_line_ctl got=%0d exp=0", de); end
  endtask

  task automatic test_mid_reset();
    logic [47:0] fr; int da, dc, ia, de; logic [39:0] rs; logic ce, ee, to;
    @(negedge clk);
    i_cmd_stb = 1'b1; i_cmd = 6'd8; i_cmd_arg = 32'h0000_01AA; i_rsps_en = 1'b1; i_crc_check = 1'b1;
    @(posedge clk);
    #1 i_cmd_stb = 1'b0;
    repeat (21) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++; if ({o_sdio_cmd_dir, o_sdio_cmd_out} !== 2'b01) begin
      n_bad++; $display("FAIL mrst_line got=%b exp=01", {o_sdio_cmd_dir, o_sdio_cmd_out}); end
    n_cmp++; if (o_idle !== 1'b1) begin n_bad++; $display("FAIL mrst_idle got=%b exp=1", o_idle); end
    n_cmp++; if (o_done_stb !== 1'b0) begin n_bad++; $display("FAIL mrst_done got=%b exp=0", o_done_stb); end
    @(negedge clk);
    rst = 1'b0;
    run_cmd(6'd8, 32'h0000_01AA, 1'b1, 1'b1, FRAME_CMD8, 5, -1, -1, fr, da, dc, ia, de, rs, ce, ee, to);
    n_cmp++; if (fr !== FRAME_CMD8) begin n_bad++; $display("FAIL mrst_frame got=%h exp=%h", fr, FRAME_CMD8); end
    n_cmp++; if (rs !== RSPS_CMD8) begin n_bad++; $display("FAIL mrst_rsps got=%h exp=%h", rs, RSPS_CMD8); end
    n_cmp++; if (da !== 101) begin n_bad++; $display("FAIL mrst_done_at got=%0d exp=101", da); end
  endtask

  initial begin
    test_reset();
    test_cmd0_no_rsp();
    test_cmd8_rsp();
    test_rsp_errors();
    test_timeout();
    test_busy_strobe();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sdio_host_cmd_phy.md
Name: sdio_host_cmd_phy

Overview:
- Host-side CMD-line PHY for SDIO; the initiator end of the device command PHY.
- Serialises a 48-bit command frame (start, direction, index, argument, CRC7, end) onto the CMD line.
- Turns the line around, waits for the device's 48-bit response within a bounded window, deserialises it, checks CRC7 and the end bit, and reports the result to the host link layer.
- Used by host-emulation benches and the host controller; runs on the SD clock, with one bit per posedge.

Parameters:
- RSPS_TIMEOUT, 64: maximum clocks from line release to response start bit (NCR).
- NRC_CYCLES, 8: minimum idle clocks after response/end bit before the next command is accepted.

Ports:
- clk  in  1  SD clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- i_cmd_stb  in  1  start command; accepted only when o_idle=1.
- i_cmd  in  6  command index, latched on accept.
- i_cmd_arg  in  32  argument, latched on accept.
- i_rsps_en  in  1  response expected, latched on accept.
- i_crc_check  in  1  check response CRC7 (0 for R3/R4), latched on accept.
- o_idle  out  1  ready for i_cmd_stb.
- o_done_stb  out  1  one-clock pulse; command and response phase complete; status outputs valid.
- o_rsps  out  40  response bits 47..8 (start, dir, index, payload), MSB first received.
- o_crc_err  out  1  received CRC7 != computed, only when checking is enabled.
- o_end_err  out  1  response end bit sampled 0.
- o_timeout  out  1  no start bit within RSPS_TIMEOUT.
- o_sdio_cmd_dir  out  1  1 = host drives CMD.
- o_sdio_cmd_out  out  1  CMD drive value.
- i_sdio_cmd_in  in  1  sampled CMD line.

Behaviour:
- Reset values:
  - state IDLE, o_idle=1, o_done_stb=0.
  - o_rsps=0, o_crc_err=0, o_end_err=0, o_timeout=0.
  - o_sdio_cmd_dir=0, o_sdio_cmd_out=1.
  - bit counter and CRC cleared.
- IDLE:
  - dir=0, out=1.
  - On i_cmd_stb, latch the inputs and build the 40-bit head {0,1,i_cmd,i_cmd_arg}.
  - Clear o_rsps and all error flags, set o_idle=0, go to CMD_TX.
- CMD_TX (bit counter 0..47):
  - The first clock after accept drives dir=1, out=0 (start bit).
  - Bits 0..39 are the head, MSB first; serial CRC7 (x^7+x^3+1) is updated on each head bit.
  - Bits 40..46 are CRC[6:0], MSB first; bit 47 is 1.
  - After bit 47: if i_rsps_en=0, go to NRC_WAIT with o_done_stb pulsed; otherwise go to TURNAROUND.
- TURNAROUND: dir=0, out=1 for 1 clock; clear the wait counter and CRC; go to WAIT_START.
- WAIT_START:
  - The wait counter increments each clock.
  - i_sdio_cmd_in==0 sampled → that bit is response bit 47 (start); go to RSPS_RX with 47 bits remaining.
  - Counter reaches RSPS_TIMEOUT with no start bit → o_timeout=1, pulse o_done_stb, go to NRC_WAIT.
  - A start bit on the same clock as expiry wins; no timeout is flagged.
- RSPS_RX:
  - Shift the start bit plus the next 39 bits into o_rsps and feed them to CRC7.
  - Capture the next 7 bits as the received CRC; the final bit is the end bit.
  - On the end-bit clock:
    - o_end_err = !end bit.
    - o_crc_err = i_crc_check && (rx_crc != computed).
    - Pulse o_done_stb, go to NRC_WAIT.
- NRC_WAIT: dir=0, out=1; count NRC_CYCLES clocks, then IDLE with o_idle=1.
- Status outputs hold their values from the o_done_stb clock until the next accept.
- Busy rules: i_cmd_stb while o_idle=0 is ignored with no side effects. The line is never driven outside CMD_TX.
- Reset mid-operation: the next edge forces dir=0, out=1, state IDLE; no o_done_stb.
- Default/illegal state: go to IDLE, release the line.
- Latency: accept → first bit 1 clock; accept → o_done_stb = 49 clocks with no response, or 48+1+W+48 clocks with a response, where W is the wait cycles.

Test Plan:
- CMD0, arg 0x00000000, i_rsps_en=0 → serial frame 0x400000000095; o_done_stb on the 48th bit clock; idle after 8 further clocks.
- CMD8, arg 0x000001AA, i_rsps_en=1, i_crc_check=1 → frame 0x48000001AA87. The bench device replies 0x48000001AA87 after 5 clocks → o_rsps=0x48000001AA, all error flags 0.
- Same exchange with response bit 20 flipped → o_crc_err=1, o_end_err=0. Repeat with i_crc_check=0 → o_crc_err=0. Repeat with a final 0 end bit → o_end_err=1.
- i_rsps_en=1 with the CMD line held at 1 → o_timeout=1 and o_done_stb exactly 64 clocks after TURNAROUND; start bit at clock 64 → no timeout.
- i_cmd_stb pulsed mid-CMD_TX and during NRC_WAIT → ignored; transmitted frame unchanged.
- rst asserted at bit 20 of CMD_TX → next edge dir=0, out=1, o_idle=1; a following command transmits correctly.
